// File: rtl/color_select_ctrl.sv
// Colour picker: two debounced push-buttons select a DAC channel and write the slide-switch value into it.
// Press latency 2 + DEBOUNCE_CYCLES cycles; register write one cycle later, LED/segment outputs one more.

module color_select_debounce #(
    parameter int DEBOUNCE_CYCLES = 400000,
    parameter int CNT_W           = 19
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic btn_raw_i,
    output logic press_o
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A level is accepted only after the synchronized input has disagreed
    // with it for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = sync2_q;
            press_d = ~sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;
endmodule

module color_select_ctrl #(
    parameter int DEBOUNCE_CYCLES = 400000,
    parameter int CNT_W           = 19
) (
    input  logic       pixel_clock,
    input  logic       reset_n,
    input  logic       btn_set_color,
    input  logic       btn_switch_color,
    input  logic [7:0] switch_color_bits,
    output logic [7:0] dac_red,
    output logic [7:0] dac_green,
    output logic [7:0] dac_blue,
    output logic [7:0] led_color_bits,
    output logic [6:0] segment_leds,
    output logic [1:0] channel_sel
);
    typedef enum logic [1:0] {
        CH_NONE  = 2'd0,
        CH_RED   = 2'd1,
        CH_GREEN = 2'd2,
        CH_BLUE  = 2'd3
    } chan_e;

    localparam logic [6:0] SEG_RED   = 7'h2F;
    localparam logic [6:0] SEG_GREEN = 7'h10;
    localparam logic [6:0] SEG_BLUE  = 7'h03;

    logic       set_evt;
    logic       switch_evt;
    logic [7:0] sw_sync1_q;
    logic [7:0] sw_sync2_q;
    chan_e      state_q;
    logic [7:0] red_q;
    logic [7:0] green_q;
    logic [7:0] blue_q;
    logic [7:0] led_q;
    logic [6:0] seg_q;

    color_select_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_set (
        .clk_i     (pixel_clock),
        .reset_n_i (reset_n),
        .btn_raw_i (btn_set_color),
        .press_o   (set_evt)
    );

    color_select_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_switch (
        .clk_i     (pixel_clock),
        .reset_n_i (reset_n),
        .btn_raw_i (btn_switch_color),
        .press_o   (switch_evt)
    );

    always_ff @(posedge pixel_clock) begin
        if (!reset_n) begin
            sw_sync1_q <= 8'hFF;
            sw_sync2_q <= 8'hFF;
        end else begin
            sw_sync1_q <= switch_color_bits;
            sw_sync2_q <= sw_sync1_q;
        end
    end

    // Set wins over a simultaneous switch; the switch press is dropped.
    always_ff @(posedge pixel_clock) begin
        if (!reset_n) begin
            state_q <= CH_RED;
            red_q   <= 8'hFF;
            green_q <= 8'h00;
            blue_q  <= 8'hDE;
            led_q   <= 8'hFF;
            seg_q   <= SEG_RED;
        end else begin
            case (state_q)
                CH_RED: begin
                    led_q <= red_q;
                    seg_q <= SEG_RED;
                end
                CH_GREEN: begin
                    led_q <= green_q;
                    seg_q <= SEG_GREEN;
                end
                CH_BLUE: begin
                    led_q <= blue_q;
                    seg_q <= SEG_BLUE;
                end
                default: begin
                    led_q <= 8'h00;
                    seg_q <= 7'h00;
                end
            endcase

            if (state_q == CH_NONE) begin
                state_q <= CH_RED;
            end else if (set_evt) begin
                case (state_q)
                    CH_RED:   red_q   <= sw_sync2_q;
                    CH_GREEN: green_q <= sw_sync2_q;
                    default:  blue_q  <= sw_sync2_q;
                endcase
            end else if (switch_evt) begin
                case (state_q)
                    CH_RED:   state_q <= CH_GREEN;
                    CH_GREEN: state_q <= CH_BLUE;
                    default:  state_q <= CH_RED;
                endcase
            end
        end
    end

    assign dac_red        = red_q;
    assign dac_green      = green_q;
    assign dac_blue       = blue_q;
    assign channel_sel    = state_q;
    assign led_color_bits = led_q;
    assign segment_leds   = seg_q;
endmodule

// File: tb/tb_color_select_ctrl.sv
// Bench for color_select_ctrl with a short debounce window and a window-rule reference model.
module tb_color_select_ctrl;
    localparam int DC = 4;

    logic       pixel_clock = 1'b0;
    logic       reset_n;
    logic       btn_set_color;
    logic       btn_switch_color;
    logic [7:0] switch_color_bits;
    logic [7:0] dac_red;
    logic [7:0] dac_green;
    logic [7:0] dac_blue;
    logic [7:0] led_color_bits;
    logic [6:0] segment_leds;
    logic [1:0] channel_sel;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 pixel_clock = ~pixel_clock;

    color_select_ctrl #(
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (3)
    ) dut (
        .pixel_clock       (pixel_clock),
        .reset_n           (reset_n),
        .btn_set_color     (btn_set_color),
        .btn_switch_color  (btn_switch_color),
        .switch_color_bits (switch_color_bits),
        .dac_red           (dac_red),
        .dac_green         (dac_green),
        .dac_blue          (dac_blue),
        .led_color_bits    (led_color_bits),
        .segment_leds      (segment_leds),
        .channel_sel       (channel_sel)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: raw samples are kept as a history; a button's accepted
    // level flips once the DC samples seen through the 2-cycle synchronizer
    // all differ from it. A press acts on the registers one cycle later.
    logic [15:0] hist_set;
    logic [15:0] hist_swc;
    logic [7:0]  hist_bits [16];
    logic        m_deb_set, m_deb_swc, m_evt_set, m_evt_swc;
    logic [7:0]  m_reg [1:3];
    int          m_chan;
    logic [7:0]  m_led;
    logic [6:0]  m_seg;
    bit          m_valid = 1'b0;

    function automatic logic [6:0] seg_of(input int ch);
        case (ch)
            1:       return 7'h2F;
            2:       return 7'h10;
            default: return 7'h03;
        endcase
    endfunction

    function automatic bit window_flips(input logic [15:0] h, input logic lvl);
        for (int i = 2; i < DC + 2; i++)
            if (h[i] === lvl) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge pixel_clock) begin
        if (!reset_n) begin
            hist_set = '1;
            hist_swc = '1;
            for (int i = 0; i < 16; i++) hist_bits[i] = 8'hFF;
            m_deb_set = 1'b1;
            m_deb_swc = 1'b1;
            m_evt_set = 1'b0;
            m_evt_swc = 1'b0;
            m_reg[1] = 8'hFF;
            m_reg[2] = 8'h00;
            m_reg[3] = 8'hDE;
            m_chan = 1;
            m_led = 8'hFF;
            m_seg = 7'h2F;
            m_valid = 1'b1;
        end else begin
            hist_set = {hist_set[14:0], btn_set_color};
            hist_swc = {hist_swc[14:0], btn_switch_color};
            for (int i = 15; i > 0; i--) hist_bits[i] = hist_bits[i-1];
            hist_bits[0] = switch_color_bits;
            m_led = m_reg[m_chan];
            m_seg = seg_of(m_chan);
            if (m_evt_set) m_reg[m_chan] = hist_bits[2];
            else if (m_evt_swc) m_chan = (m_chan == 3) ? 1 : m_chan + 1;
            m_evt_set = 1'b0;
            m_evt_swc = 1'b0;
            if (window_flips(hist_set, m_deb_set)) begin
                m_deb_set = ~m_deb_set;
                m_evt_set = ~m_deb_set;
            end
            if (window_flips(hist_swc, m_deb_swc)) begin
                m_deb_swc = ~m_deb_swc;
                m_evt_swc = ~m_deb_swc;
            end
        end
        #1;
        if (m_valid) begin
            check("model dac_red", dac_red, m_reg[1]);
            check("model dac_green", dac_green, m_reg[2]);
            check("model dac_blue", dac_blue, m_reg[3]);
            check("model channel_sel", channel_sel, m_chan);
            check("model led", led_color_bits, m_led);
            check("model seg", segment_leds, m_seg);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge pixel_clock);
    endtask

    task automatic press_switch();
        btn_switch_color = 1'b0;
        cycles(8);
        btn_switch_color = 1'b1;
        cycles(10);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " red"}, dac_red, 8'hFF);
        check({tag, " green"}, dac_green, 8'h00);
        check({tag, " blue"}, dac_blue, 8'hDE);
        check({tag, " led"}, led_color_bits, 8'hFF);
        check({tag, " seg"}, segment_leds, 7'h2F);
        check({tag, " chan"}, channel_sel, 2'd1);
    endtask

    logic [1:0] exp_chan [3];
    logic [6:0] exp_seg  [3];
    logic [7:0] exp_led  [3];

    initial begin
        exp_chan = '{2'd2, 2'd3, 2'd1};
        exp_seg  = '{7'h10, 7'h03, 7'h2F};
        exp_led  = '{8'h00, 8'hDE, 8'hFF};
        reset_n = 1'b0;
        btn_set_color = 1'b1;
        btn_switch_color = 1'b1;
        switch_color_bits = 8'h00;
        cycles(3);
        reset_n = 1'b1;

        // Idle after reset
        cycles(10);
        check_reset_vals("idle");

        // Three clean channel advances
        for (int k = 0; k < 3; k++) begin
            press_switch();
            check("adv chan", channel_sel, exp_chan[k]);
            check("adv seg", segment_leds, exp_seg[k]);
            check("adv led", led_color_bits, exp_led[k]);
        end

        // Write 3C into red: visible at the 7th edge, LED at the 8th
        switch_color_bits = 8'h3C;
        cycles(4);
        btn_set_color = 1'b0;
        cycles(6);
        check("set early red", dac_red, 8'hFF);
        cycles(1);
        check("set red", dac_red, 8'h3C);
        check("set led early", led_color_bits, 8'hFF);
        cycles(1);
        check("set led", led_color_bits, 8'h3C);
        cycles(12);
        btn_set_color = 1'b1;
        cycles(10);
        check("set green kept", dac_green, 8'h00);
        check("set blue kept", dac_blue, 8'hDE);
        check("set red held", dac_red, 8'h3C);

        // Bounce shorter than the window
        for (int i = 0; i < 30; i++) begin
            btn_switch_color = logic'((i >> 1) & 1);
            cycles(1);
        end
        btn_switch_color = 1'b1;
        cycles(12);
        check("bounce chan", channel_sel, 2'd1);

        // Simultaneous set and switch in GREEN
        press_switch();
        check("pre both chan", channel_sel, 2'd2);
        switch_color_bits = 8'h55;
        cycles(4);
        btn_set_color = 1'b0;
        btn_switch_color = 1'b0;
        cycles(8);
        btn_set_color = 1'b1;
        btn_switch_color = 1'b1;
        cycles(10);
        check("both green", dac_green, 8'h55);
        check("both chan", channel_sel, 2'd2);
        check("both red", dac_red, 8'h3C);

        // Button held low across reset release
        switch_color_bits = 8'hA5;
        btn_set_color = 1'b0;
        reset_n = 1'b0;
        cycles(2);
        check_reset_vals("in reset");
        reset_n = 1'b1;
        cycles(6);
        check("held early red", dac_red, 8'hFF);
        cycles(1);
        check("held red", dac_red, 8'hA5);
        btn_set_color = 1'b1;
        cycles(10);

        // One-cycle reset mid-debounce cancels the pending press
        switch_color_bits = 8'h11;
        cycles(4);
        btn_set_color = 1'b0;
        cycles(3);
        reset_n = 1'b0;
        cycles(1);
        reset_n = 1'b1;
        cycles(1);
        btn_set_color = 1'b1;
        cycles(12);
        check_reset_vals("mid reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/color_select_ctrl.md
COLOR_SELECT_CTRL -- requirements
Module: color_select_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 400000, meaning consecutive stable pixel_clock cycles (10 ms at 40 MHz) required to accept a button level.
REQ-002 SHALL have parameter CNT_W, default 19, meaning width of each debounce counter; CNT_W SHALL hold DEBOUNCE_CYCLES-1.
REQ-003 SHALL have port pixel_clock  input  1  sole clock, 40 MHz pixel clock.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous to pixel_clock, active-low.
REQ-005 SHALL have port btn_set_color  input  1  asynchronous push-button, active-low; write switches into selected channel.
REQ-006 SHALL have port btn_switch_color  input  1  asynchronous push-button, active-low; advance selected channel.
REQ-007 SHALL have port switch_color_bits  input  8  asynchronous slide switches, channel write value.
REQ-008 SHALL have port dac_red  output  8  red channel value to DAC.
REQ-009 SHALL have port dac_green  output  8  green channel value to DAC.
REQ-010 SHALL have port dac_blue  output  8  blue channel value to DAC.
REQ-011 SHALL have port led_color_bits  output  8  value of currently selected channel.
REQ-012 SHALL have port segment_leds  output  7  channel indicator pattern.
REQ-013 SHALL have port channel_sel  output  2  selected channel: 1 red, 2 green, 3 blue.

Function
REQ-014 All state SHALL update on the rising edge of pixel_clock only; no logic clocked by button edges.
REQ-015 Each button and all 8 switch bits SHALL pass through a 2-flop synchronizer before use.
REQ-016 Per button: counter clears when synchronized level equals debounced level; else increments; when counter reaches DEBOUNCE_CYCLES-1 debounced level takes synchronized level and counter clears.
REQ-017 A press event SHALL be a single-cycle pulse on the debounced 1->0 transition; release (0->1) SHALL produce no event.
REQ-018 A button held low indefinitely SHALL produce exactly one press event; bounce shorter than DEBOUNCE_CYCLES SHALL produce none.
REQ-019 Press event latency SHALL be exactly 2 + DEBOUNCE_CYCLES cycles after the raw input goes low and stays low.
REQ-020 Channel FSM states: RED(1), GREEN(2), BLUE(3); switch event transitions RED->GREEN->BLUE->RED; encoding 0 unreachable, and if entered SHALL go to RED next cycle.
REQ-021 Set event SHALL load the synchronized switch value into the register of the current state in the cycle after the event; other registers unchanged.
REQ-022 Set and switch events in the same cycle: set SHALL be performed, switch SHALL be discarded (not deferred).
REQ-023 led_color_bits and segment_leds SHALL be registered, one cycle after the state/channel register change.
REQ-024 segment_leds SHALL be 7'h2F in RED, 7'h10 in GREEN, 7'h03 in BLUE.
REQ-025 dac_red/green/blue SHALL be driven directly from channel registers; channel_sel directly from state.

Reset
REQ-026 While reset_n is low at a clock edge: dac_red=8'hFF, dac_green=8'h00, dac_blue=8'hDE, state RED, channel_sel=2'd1, led_color_bits=8'hFF, segment_leds=7'h2F.
REQ-027 Reset SHALL set debounced levels to 1 (released), clear counters, set synchronizer flops to 1, and cancel any press in progress.
REQ-028 A button held low across reset release SHALL generate one press event, DEBOUNCE_CYCLES+2 cycles after reset release.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Reset, no stimulus -> outputs FF/00/DE, led FF, seg 2F, channel_sel 1, stable.
REQ-030 Switches 8'h3C, btn_set_color low 20 cycles -> dac_red=8'h3C at cycle 7 after press, led 3C at cycle 8, green/blue unchanged.
REQ-031 Three clean btn_switch_color presses -> channel_sel 2,3,1; seg 10,03,2F; led 00,DE,FF.
REQ-032 btn_switch_color toggled every 2 cycles for 30 cycles then released -> no channel change.
REQ-033 Both buttons low in same cycle, switches 8'h55, state GREEN -> dac_green=8'h55, channel_sel stays 2.
REQ-034 reset_n low for 1 cycle mid-debounce of btn_set_color -> no write; outputs return to reset values.
